// File: rtl/split_rr_burst_arbiter_pkg.sv
// Shared types for the split round-robin burst arbiter.
package split_arb_pkg;
  typedef enum logic {ARB_IDLE = 1'b0, ARB_BUSY = 1'b1} arb_state_e;
endpackage

// File: rtl/split_rr_burst_arbiter_if.sv
// Requester-side and consumer-side signals of the arbiter, grouped for port connection.
interface split_rr_burst_arbiter_if #(
  parameter int N = 4,
  parameter int W = 16
);
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]    req;
  logic [N-1:0]    last;
  logic [N*W-1:0]  data;
  logic [N-1:0]    ack;
  logic            out_valid;
  logic            out_ready;
  logic [IDXW-1:0] out_idx;
  logic [W-1:0]    out_data;
  logic            out_last;

  modport master (
    output req, last, data, out_ready,
    input  ack, out_valid, out_idx, out_data, out_last
  );

  modport slave (
    input  req, last, data, out_ready,
    output ack, out_valid, out_idx, out_data, out_last
  );
endinterface

// File: rtl/split_rr_burst_arbiter_rr_pick.sv
// Rotating-priority picker: first set request bit scanning from i_ptr upward with wrap.
module rr_pick #(
  parameter int N = 4,
  localparam int IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    i_req,
  input  logic [IDXW-1:0] i_ptr,
  output logic            o_found,
  output logic [IDXW-1:0] o_idx
);
  logic [N-1:0] w_rot;
  int           w_sum;

  // Bit j of w_rot is request (ptr + j) mod N.
  assign w_rot = N'({i_req, i_req} >> i_ptr);

  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_sum   = 0;
    for (int j = N - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_sum = int'(i_ptr) + j;
        if (w_sum >= N) w_sum = w_sum - N;
        o_found = 1'b1;
        o_idx   = IDXW'(w_sum);
      end
    end
  end
endmodule

// File: rtl/split_rr_burst_arbiter.sv
// Round-robin arbiter with burst locking; one granted requester drives the output
// channel until its last beat or the MAX_BURST-th beat.
module split_rr_burst_arbiter
  import split_arb_pkg::*;
#(
  parameter int N         = 4,
  parameter int W         = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  split_rr_burst_arbiter_if.slave bus
);
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam int CNTW = $clog2(MAX_BURST + 1);

  typedef struct packed {
    logic            busy;
    logic [IDXW-1:0] idx;
    logic [CNTW-1:0] cnt;
  } grant_t;

`ifdef ENABLE_SPLIT_VAR
  (* split_var *) grant_t r_grant;
`else
  grant_t r_grant;
`endif

  arb_state_e      r_state, w_state_nxt;
  logic [IDXW-1:0] r_ptr, w_ptr_nxt, w_idx_nxt;
  logic [CNTW-1:0] w_cnt_nxt;
  logic [IDXW-1:0] w_pick_ptr, w_pick_idx;
  logic [N-1:0]    w_pick_req, w_gnt_oh;
  logic            w_pick_found, w_active, w_valid, w_last, w_xfer;

  function automatic logic [IDXW-1:0] inc_mod(input logic [IDXW-1:0] v);
    return (int'(v) == N - 1) ? '0 : v + IDXW'(1);
  endfunction

  // Outputs are gated by rst so an in-flight burst never acks during reset.
  assign w_gnt_oh = N'(1) << r_grant.idx;
  assign w_active = r_grant.busy & ~rst;
  assign w_valid  = w_active & |(bus.req & w_gnt_oh);
  assign w_last   = w_active & (|(bus.last & w_gnt_oh) |
                                (r_grant.cnt == CNTW'(MAX_BURST - 1)));
  assign w_xfer   = w_valid & bus.out_ready;

  // Handover scan starts after the current owner and never re-picks it.
  assign w_pick_ptr = (r_state == ARB_IDLE) ? r_ptr : inc_mod(r_grant.idx);
  assign w_pick_req = (r_state == ARB_IDLE) ? bus.req : (bus.req & ~w_gnt_oh);

  rr_pick #(.N(N)) u_pick (
    .i_req   (w_pick_req),
    .i_ptr   (w_pick_ptr),
    .o_found (w_pick_found),
    .o_idx   (w_pick_idx)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_grant.idx;
    w_cnt_nxt   = r_grant.cnt;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ARB_IDLE: begin
        if (w_pick_found) begin
          w_state_nxt = ARB_BUSY;
          w_idx_nxt   = w_pick_idx;
          w_cnt_nxt   = '0;
        end
      end
      ARB_BUSY: begin
        if (w_xfer) begin
          if (w_last) begin
            w_ptr_nxt = inc_mod(r_grant.idx);
            w_cnt_nxt = '0;
            if (w_pick_found) w_idx_nxt = w_pick_idx;
            else              w_state_nxt = ARB_IDLE;
          end else begin
            w_cnt_nxt = r_grant.cnt + CNTW'(1);
          end
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ARB_IDLE;
      r_grant.busy <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant.busy <= (w_state_nxt == ARB_BUSY);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_grant.idx <= '0;
    else     r_grant.idx <= w_idx_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) r_grant.cnt <= '0;
    else     r_grant.cnt <= w_cnt_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) r_ptr <= '0;
    else     r_ptr <= w_ptr_nxt;
  end

  always_comb begin
    bus.ack       = w_xfer ? w_gnt_oh : '0;
    bus.out_valid = w_valid;
    bus.out_last  = w_last;
    bus.out_idx   = w_active ? r_grant.idx : '0;
    bus.out_data  = '0;
    for (int k = 0; k < N; k++) begin
      if (w_active && (r_grant.idx == IDXW'(k))) bus.out_data = bus.data[k*W +: W];
    end
  end
endmodule

// File: tb/tb_split_rr_burst_arbiter.sv
// Scenario bench for split_rr_burst_arbiter: directed cases plus a randomized run
// checked against a transaction-level model of the arbitration rules.
module tb_split_rr_burst_arbiter;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  split_rr_burst_arbiter_if #(.N(N), .W(W)) bus ();

  split_rr_burst_arbiter #(.N(N), .W(W), .MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Tuple observed each cycle: {valid, idx, ack, last, data}.
  function automatic logic [23:0] obs();
    return {bus.out_valid, bus.out_idx, bus.ack, bus.out_last, bus.out_data};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0; bus.last = '0; bus.data = '0; bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = 4'b1111; bus.last = 4'b1111; bus.out_ready = 1'b1;
    bus.data = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
    for (int c = 0; c < 2; c++) begin
      #2;
      total++;
      if (obs() !== 24'h0) begin
        bad++; $display("FAIL reset_hold cyc=%0d got=%h want=%h", c, obs(), 24'h0);
      end
      tick();
    end
    rst = 1'b0;
    #2;
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_rel1 got valid=%b want 0", bus.out_valid);
    end
    tick();
    #2;
    total++;
    if (obs() !== {1'b1, 2'd0, 4'b0001, 1'b1, 16'h1000}) begin
      bad++; $display("FAIL reset_rel2 got=%h want=%h", obs(), {1'b1, 2'd0, 4'b0001, 1'b1, 16'h1000});
    end
  endtask

  task automatic test_round_robin();
    logic [23:0] exp;
    do_reset();
    bus.req = 4'b1111; bus.last = 4'b1111; bus.out_ready = 1'b1;
    bus.data = {16'h2003, 16'h2002, 16'h2001, 16'h2000};
    #2;
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL rr_idle got valid=%b want 0", bus.out_valid);
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      #2;
      exp = {1'b1, 2'(i % 4), 4'(1 << (i % 4)), 1'b1, 16'h2000 + 16'(i % 4)};
      total++;
      if (obs() !== exp) begin
        bad++; $display("FAIL rr_seq beat=%0d got=%h want=%h", i, obs(), exp);
      end
      tick();
    end
  endtask

  task automatic test_burst_stall();
    logic [15:0] dv [4] = '{16'hA001, 16'hA002, 16'hA002, 16'hA003};
    logic        rd [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic        li [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0]  ak [4] = '{4'b0100, 4'b0000, 4'b0100, 4'b0100};
    logic [23:0] exp;
    do_reset();
    bus.req = 4'b0100; bus.last = '0; bus.out_ready = 1'b1;
    bus.data[1*W +: W] = 16'hB001;
    tick();
    bus.req = 4'b0110;
    for (int b = 0; b < 4; b++) begin
      bus.data[2*W +: W] = dv[b];
      bus.out_ready      = rd[b];
      bus.last[2]        = li[b];
      #2;
      exp = {1'b1, 2'd2, ak[b], li[b], dv[b]};
      total++;
      if (obs() !== exp) begin
        bad++; $display("FAIL burst_stall beat=%0d got=%h want=%h", b, obs(), exp);
      end
      tick();
    end
    bus.req = 4'b0010; bus.last = '0;
    #2;
    total++;
    if (obs() !== {1'b1, 2'd1, 4'b0010, 1'b0, 16'hB001}) begin
      bad++; $display("FAIL burst_next got=%h want=%h", obs(), {1'b1, 2'd1, 4'b0010, 1'b0, 16'hB001});
    end
  endtask

  task automatic test_forced_release();
    int          acks = 0;
    logic [23:0] exp;
    do_reset();
    bus.req = 4'b1000; bus.last = '0; bus.out_ready = 1'b1;
    bus.data[0 +: W] = 16'hD000;
    tick();
    bus.req = 4'b1001;
    for (int b = 0; b < 4; b++) begin
      bus.data[3*W +: W] = 16'hC000 + 16'(b);
      #2;
      exp = {1'b1, 2'd3, 4'b1000, (b == 3), 16'hC000 + 16'(b)};
      total++;
      if (obs() !== exp) begin
        bad++; $display("FAIL forced_beat beat=%0d got=%h want=%h", b, obs(), exp);
      end
      if (bus.ack[3]) acks++;
      tick();
    end
    #2;
    if (bus.ack[3]) acks++;
    total++;
    if (acks != 4) begin
      bad++; $display("FAIL forced_ackcnt got=%0d want=4", acks);
    end
    total++;
    if (obs() !== {1'b1, 2'd0, 4'b0001, 1'b0, 16'hD000}) begin
      bad++; $display("FAIL forced_next got=%h want=%h", obs(), {1'b1, 2'd0, 4'b0001, 1'b0, 16'hD000});
    end
  endtask

  task automatic test_req_drop();
    do_reset();
    bus.req = 4'b0010; bus.last = '0; bus.out_ready = 1'b1;
    bus.data = {16'h0, 16'h0, 16'hE001, 16'hF000};
    tick();
    bus.req = 4'b0011;
    #2;
    total++;
    if (obs() !== {1'b1, 2'd1, 4'b0010, 1'b0, 16'hE001}) begin
      bad++; $display("FAIL drop_first got=%h want=%h", obs(), {1'b1, 2'd1, 4'b0010, 1'b0, 16'hE001});
    end
    tick();
    bus.req = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      #2;
      total++;
      if ({bus.out_valid, bus.out_idx, bus.ack} !== {1'b0, 2'd1, 4'b0000}) begin
        bad++; $display("FAIL drop_hold cyc=%0d got=%h want=%h", c,
                        {bus.out_valid, bus.out_idx, bus.ack}, {1'b0, 2'd1, 4'b0000});
      end
      tick();
    end
    bus.req = 4'b0011; bus.last = 4'b0010;
    #2;
    total++;
    if (obs() !== {1'b1, 2'd1, 4'b0010, 1'b1, 16'hE001}) begin
      bad++; $display("FAIL drop_resume got=%h want=%h", obs(), {1'b1, 2'd1, 4'b0010, 1'b1, 16'hE001});
    end
    tick();
    bus.req = 4'b0001; bus.last = '0;
    #2;
    total++;
    if (obs() !== {1'b1, 2'd0, 4'b0001, 1'b0, 16'hF000}) begin
      bad++; $display("FAIL drop_next got=%h want=%h", obs(), {1'b1, 2'd0, 4'b0001, 1'b0, 16'hF000});
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    bus.req = 4'b0100; bus.last = 4'b0100; bus.out_ready = 1'b1;
    bus.data = {16'h3003, 16'h3002, 16'h3001, 16'h3000};
    tick();
    #2;
    total++;
    if (obs() !== {1'b1, 2'd2, 4'b0100, 1'b1, 16'h3002}) begin
      bad++; $display("FAIL rstmid_single got=%h want=%h", obs(), {1'b1, 2'd2, 4'b0100, 1'b1, 16'h3002});
    end
    tick();
    tick();
    bus.last = '0;
    #2;
    total++;
    if (obs() !== {1'b1, 2'd2, 4'b0100, 1'b0, 16'h3002}) begin
      bad++; $display("FAIL rstmid_beat1 got=%h want=%h", obs(), {1'b1, 2'd2, 4'b0100, 1'b0, 16'h3002});
    end
    tick();
    rst = 1'b1;
    #2;
    total++;
    if (obs() !== 24'h0) begin
      bad++; $display("FAIL rstmid_during got=%h want=%h", obs(), 24'h0);
    end
    tick();
    rst = 1'b0; bus.req = 4'b1111;
    #2;
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL rstmid_after got valid=%b want 0", bus.out_valid);
    end
    tick();
    #2;
    total++;
    if ({bus.out_valid, bus.out_idx} !== {1'b1, 2'd0}) begin
      bad++; $display("FAIL rstmid_ptr got=%b/%0d want=1/0", bus.out_valid, bus.out_idx);
    end
  endtask

  // First requester at or after start (wrapping), skipping excl; -1 when none.
  function automatic int first_from(logic [N-1:0] r, int start, int excl);
    for (int i = 0; i < N; i++) begin
      if (((start + i) % N) != excl && r[(start + i) % N]) return (start + i) % N;
    end
    return -1;
  endfunction

  task automatic test_random();
    bit          owned = 0;
    int          owner = 0, nxt_start = 0, beats = 0, cand;
    logic        e_valid, e_last;
    logic [3:0]  e_ack;
    logic [1:0]  e_idx;
    logic [15:0] e_data;
    logic [N*W-1:0] d;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst           = ($urandom_range(0, 79) == 0);
      bus.req       = 4'($urandom_range(0, 15));
      bus.last      = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      d             = {$urandom, $urandom};
      bus.data      = d;
      #2;
      e_valid = !rst && owned && bus.req[owner];
      e_last  = !rst && owned && (bus.last[owner] || beats == MB - 1);
      e_idx   = (!rst && owned) ? 2'(owner) : 2'd0;
      e_data  = (!rst && owned) ? d[owner*W +: W] : 16'h0;
      e_ack   = (e_valid && bus.out_ready) ? 4'(1 << owner) : 4'b0;
      total++;
      if (obs() !== {e_valid, e_idx, e_ack, e_last, e_data}) begin
        bad++; $display("FAIL rand cyc=%0d got=%h want=%h", c, obs(), {e_valid, e_idx, e_ack, e_last, e_data});
      end
      if (rst) begin
        owned = 0; owner = 0; nxt_start = 0; beats = 0;
      end else if (!owned) begin
        cand = first_from(bus.req, nxt_start, -1);
        if (cand >= 0) begin owned = 1; owner = cand; beats = 0; end
      end else if (e_valid && bus.out_ready) begin
        if (e_last) begin
          nxt_start = (owner + 1) % N;
          beats = 0;
          cand = first_from(bus.req, nxt_start, owner);
          if (cand >= 0) owner = cand;
          else owned = 0;
        end else begin
          beats++;
        end
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_burst_stall();
    test_forced_release();
    test_req_drop();
    test_reset_mid_burst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
